tx_frame_sched: RTL and testbench

Transmit frame scheduler for the CAN XL transmit path. It arbitrates among NREQ transmit buffers by CAN priority ID and drives the parallel-to-serial converter handshake: start pulse, DLC, and data-mux select. It then tracks completion, bus result, retries and timeouts, and returns a per-requester acknowledge or abort. It sits between the TX buffer bank and the serializer/FCRC path.

---
 rtl/tx_frame_sched.sv | 166 ++++++++++++++++
 tb/tb_tx_frame_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_sched.sv
// Transmit frame scheduler: picks the highest-priority pending TX buffer, drives the
// parallel-to-serial converter handshake, and handles retries, timeouts, ack and abort.
module tx_frame_sched #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TO_CYC    = 16600,
    localparam int unsigned SEL_W    = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                g_rst,
    input  logic [NREQ-1:0]     req,
    input  logic [11*NREQ-1:0]  prio,
    input  logic [11*NREQ-1:0]  dlc_in,
    input  logic                tx_fcrc_intl,
    input  logic                tx_fcrc_frm_cmp,
    input  logic                tx_success,
    input  logic                tx_error,
    output logic                par_ser_intl1,
    output logic [10:0]         dlc,
    output logic [SEL_W-1:0]    sel,
    output logic                ser_flush,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     abort,
    output logic                busy
);

    localparam int unsigned CNT_W = $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETRY);
    localparam logic [15:0]      TO_LAST = 16'(TO_CYC - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARB    = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_SER    = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;
    localparam logic [2:0] S_FLUSH  = 3'd5;
    localparam logic [2:0] S_ACK    = 3'd6;

    logic [2:0]       state, state_nxt;
    logic [15:0]      timer, timer_nxt;
    logic [CNT_W-1:0] attempt_cnt, attempt_cnt_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [10:0]      dlc_nxt;
    logic             par_ser_nxt, ser_flush_nxt;
    logic [NREQ-1:0]  ack_nxt, abort_nxt;
    logic             fail;

    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic [10:0]      win_prio;
    logic [10:0]      win_dlc;

    // Lowest prio among pending requests; strict compare keeps ties on the lower index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_prio  = '1;
        win_dlc   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (req[i] && (!win_found || (prio[11*i +: 11] < win_prio))) begin
                win_found = 1'b1;
                win_idx   = SEL_W'(i);
                win_prio  = prio[11*i +: 11];
                win_dlc   = dlc_in[11*i +: 11];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        timer_nxt       = timer;
        attempt_cnt_nxt = attempt_cnt;
        sel_nxt         = sel;
        dlc_nxt         = dlc;
        par_ser_nxt     = 1'b0;
        ser_flush_nxt   = 1'b0;
        ack_nxt         = '0;
        abort_nxt       = '0;
        fail            = 1'b0;

        case (state)
            S_IDLE: begin
                if ((|req) && tx_fcrc_intl) state_nxt = S_ARB;
            end
            S_ARB: begin
                if (win_found) begin
                    sel_nxt = win_idx;
                    dlc_nxt = win_dlc;
                    if (win_idx != sel) attempt_cnt_nxt = '0;
                    state_nxt = S_START;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_START: begin
                par_ser_nxt = 1'b1;
                timer_nxt   = '0;
                state_nxt   = S_SER;
            end
            S_SER: begin
                timer_nxt = timer + 16'd1;
                if (tx_fcrc_frm_cmp) begin
                    timer_nxt = '0;
                    state_nxt = S_RESULT;
                end else if (timer == TO_LAST) begin
                    fail = 1'b1;
                end
            end
            S_RESULT: begin
                timer_nxt = timer + 16'd1;
                if (tx_success) state_nxt = S_ACK;
                else if (tx_error || (timer == TO_LAST)) fail = 1'b1;
            end
            S_FLUSH: begin
                if (tx_fcrc_intl) state_nxt = S_ARB;
            end
            S_ACK: begin
                ack_nxt         = NREQ'(1) << sel;
                attempt_cnt_nxt = '0;
                state_nxt       = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // A failed attempt always flushes the converter; the retry budget decides retry vs. drop.
        if (fail) begin
            ser_flush_nxt = 1'b1;
            if (attempt_cnt < MAX_CNT) begin
                attempt_cnt_nxt = attempt_cnt + CNT_W'(1);
                state_nxt       = S_FLUSH;
            end else begin
                abort_nxt       = NREQ'(1) << sel;
                attempt_cnt_nxt = '0;
                state_nxt       = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (g_rst) begin
            state         <= S_IDLE;
            timer         <= '0;
            attempt_cnt   <= '0;
            sel           <= '0;
            dlc           <= '0;
            par_ser_intl1 <= 1'b0;
            ser_flush     <= 1'b0;
            ack           <= '0;
            abort         <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            attempt_cnt   <= attempt_cnt_nxt;
            sel           <= sel_nxt;
            dlc           <= dlc_nxt;
            par_ser_intl1 <= par_ser_nxt;
            ser_flush     <= ser_flush_nxt;
            ack           <= ack_nxt;
            abort         <= abort_nxt;
            busy          <= (state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed self-checking bench for tx_frame_sched (NREQ=4, MAX_RETRY=3, TO_CYC=100).
module tb_tx_frame_sched;

    localparam int unsigned NREQ = 4;

    logic        clk = 1'b0;
    logic        g_rst;
    logic [3:0]  req;
    logic [43:0] prio;
    logic [43:0] dlc_in;
    logic        tx_fcrc_intl;
    logic        tx_fcrc_frm_cmp;
    logic        tx_success;
    logic        tx_error;
    logic        par_ser_intl1;
    logic [10:0] dlc;
    logic [1:0]  sel;
    logic        ser_flush;
    logic [3:0]  ack;
    logic [3:0]  abort;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    tx_frame_sched #(.NREQ(NREQ), .MAX_RETRY(3), .TO_CYC(100)) dut (
        .clk             (clk),
        .g_rst           (g_rst),
        .req             (req),
        .prio            (prio),
        .dlc_in          (dlc_in),
        .tx_fcrc_intl    (tx_fcrc_intl),
        .tx_fcrc_frm_cmp (tx_fcrc_frm_cmp),
        .tx_success      (tx_success),
        .tx_error        (tx_error),
        .par_ser_intl1   (par_ser_intl1),
        .dlc             (dlc),
        .sel             (sel),
        .ser_flush       (ser_flush),
        .ack             (ack),
        .abort           (abort),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_buf(input int idx, input logic [10:0] p, input logic [10:0] d);
        prio[11*idx +: 11]   = p;
        dlc_in[11*idx +: 11] = d;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!par_ser_intl1 && n < 300);
        chk("start_seen", 16'(par_ser_intl1), 16'd1);
    endtask

    // Converter finishes, then the controller reports success (ok=1) or error (ok=0).
    task automatic serve(input logic ok);
        tx_fcrc_frm_cmp = 1'b1;
        tick();
        tx_fcrc_frm_cmp = 1'b0;
        tx_success = ok;
        tx_error   = !ok;
        tick();
        tx_success = 1'b0;
        tx_error   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        int pulses;
        g_rst = 1'b1; req = '0; prio = '0; dlc_in = '0;
        tx_fcrc_intl = 1'b1; tx_fcrc_frm_cmp = 1'b0; tx_success = 1'b0; tx_error = 1'b0;
        tick(); tick();
        chk("rst_par", 16'(par_ser_intl1), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_sel", 16'(sel), 16'd0);
        chk("rst_dlc", 16'(dlc), 16'd0);
        chk("rst_ack_abort", 16'({ack, abort, ser_flush}), 16'd0);
        g_rst = 1'b0;
        tick();

        // Single frame
        set_buf(0, 11'h100, 11'h000);
        req = 4'b0001;
        wait_start(n);
        chk("t1_start_lat", 16'(n), 16'd3);
        chk("t1_sel", 16'(sel), 16'd0);
        chk("t1_dlc", 16'(dlc), 16'd0);
        chk("t1_busy", 16'(busy), 16'd1);
        tick();
        chk("t1_pulse_width", 16'(par_ser_intl1), 16'd0);
        req = '0;
        serve(1'b1);
        chk("t1_ack_early", 16'(ack), 16'd0);
        tick();
        chk("t1_ack", 16'(ack), 16'b0001);
        chk("t1_busy_ack", 16'(busy), 16'd1);
        tick();
        chk("t1_ack_len", 16'(ack), 16'd0);
        chk("t1_busy_low", 16'(busy), 16'd0);
        tick();

        // Priority: 3 beats 1
        set_buf(1, 11'h050, 11'h011);
        set_buf(3, 11'h020, 11'h033);
        req = 4'b1010;
        wait_start(n);
        chk("t2_sel_a", 16'(sel), 16'd3);
        chk("t2_dlc_a", 16'(dlc), 16'h033);
        req = 4'b0010;
        serve(1'b1);
        tick();
        chk("t2_ack_a", 16'(ack), 16'b1000);
        wait_start(n);
        chk("t2_sel_b", 16'(sel), 16'd1);
        chk("t2_dlc_b", 16'(dlc), 16'h011);
        req = '0;
        serve(1'b1);
        tick();
        chk("t2_ack_b", 16'(ack), 16'b0010);
        tick(); tick();

        // Tie goes to the lower index
        set_buf(0, 11'h123, 11'h00A);
        set_buf(2, 11'h123, 11'h00C);
        req = 4'b0101;
        wait_start(n);
        chk("t2_tie_sel", 16'(sel), 16'd0);
        chk("t2_tie_dlc", 16'(dlc), 16'h00A);
        req = '0;
        serve(1'b1);
        tick();
        chk("t2_tie_ack", 16'(ack), 16'b0001);
        tick(); tick();

        // Retry exhaustion: 4 attempts, abort with the 4th flush
        set_buf(0, 11'h100, 11'h07F);
        req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            wait_start(n);
            serve(1'b0);
            chk("t3_flush", 16'(ser_flush), 16'd1);
            chk("t3_abort", 16'(abort), (k == 3) ? 16'b0001 : 16'd0);
            chk("t3_noack", 16'(ack), 16'd0);
        end
        req = '0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (par_ser_intl1 || ser_flush || (|ack) || (|abort)) pulses++;
        end
        chk("t3_quiet", 16'(pulses), 16'd0);
        chk("t3_idle", 16'(busy), 16'd0);

        // Timeout in SER
        set_buf(1, 11'h0AA, 11'h155);
        req = 4'b0010;
        wait_start(n);
        m = 0;
        do begin
            tick();
            m++;
        end while (!ser_flush && m < 300);
        chk("t4_timeout_cyc", 16'(m), 16'd100);
        chk("t4_abort", 16'(abort), 16'd0);
        tx_fcrc_intl = 1'b0;
        tick(); tick(); tick();
        chk("t4_hold_start", 16'(par_ser_intl1), 16'd0);
        chk("t4_hold_busy", 16'(busy), 16'd1);
        tx_fcrc_intl = 1'b1;
        wait_start(n);
        chk("t4_retry_lat", 16'(n), 16'd3);
        chk("t4_retry_sel", 16'(sel), 16'd1);
        req = '0;
        serve(1'b1);
        tick();
        chk("t4_ack", 16'(ack), 16'b0010);
        tick(); tick();

        // Pre-emption on retry
        set_buf(0, 11'h200, 11'h200);
        set_buf(2, 11'h010, 11'h222);
        req = 4'b0001;
        wait_start(n);
        chk("t5_sel0", 16'(sel), 16'd0);
        tx_fcrc_frm_cmp = 1'b1;
        tick();
        tx_fcrc_frm_cmp = 1'b0;
        req = 4'b0101;
        tx_error = 1'b1;
        tick();
        tx_error = 1'b0;
        chk("t5_flush", 16'(ser_flush), 16'd1);
        chk("t5_abort", 16'(abort), 16'd0);
        wait_start(n);
        chk("t5_preempt_sel", 16'(sel), 16'd2);
        chk("t5_preempt_dlc", 16'(dlc), 16'h222);
        req = 4'b0001;
        serve(1'b1);
        tick();
        chk("t5_ack2", 16'(ack), 16'b0100);
        for (int k = 0; k < 4; k++) begin
            wait_start(n);
            chk("t5_sel_retry", 16'(sel), 16'd0);
            serve(1'b0);
            chk("t5_abort_k", 16'(abort), (k == 3) ? 16'b0001 : 16'd0);
        end
        req = '0;
        tick(); tick();

        // Reset mid-SER
        set_buf(3, 11'h300, 11'h3AB);
        req = 4'b1000;
        wait_start(n);
        chk("t6_sel", 16'(sel), 16'd3);
        tick();
        g_rst = 1'b1;
        req = '0;
        tick();
        g_rst = 1'b0;
        chk("t6_par", 16'(par_ser_intl1), 16'd0);
        chk("t6_sel_rst", 16'(sel), 16'd0);
        chk("t6_dlc_rst", 16'(dlc), 16'd0);
        chk("t6_busy_rst", 16'(busy), 16'd0);
        chk("t6_pulses_rst", 16'({ack, abort, ser_flush}), 16'd0);
        tx_fcrc_frm_cmp = 1'b1;
        tick();
        tx_fcrc_frm_cmp = 1'b0;
        tx_success = 1'b1;
        tick();
        tx_success = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if ((|ack) || (|abort) || busy || par_ser_intl1) pulses++;
        end
        chk("t6_no_ack", 16'(pulses), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
